// File: rtl/avalon_pio_ext.sv
// avalon_pio_ext: zero-wait-state Avalon-MM PIO with atomic output
// set/clear, synchronised inputs, per-bit edge capture and masked irq.
// Optional blink unit on the outputs, enabled by macro PIO_BLINK_EN.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   address    register word select (0..7)
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  write data, bits above WIDTH ignored
//   readdata   combinational read data, zero-extended
//   in_port    asynchronous external inputs
//   out_port   output pins
//   irq        level interrupt, |(EDGECAP & IRQMASK)
module avalon_pio_ext #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int              EDGE_TYPE   = 0,
    parameter int              SYNC_STAGES = 2,
    parameter int              BLINK_W     = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam logic [2:0] A_DATA    = 3'd0;
    localparam logic [2:0] A_INPUT   = 3'd1;
    localparam logic [2:0] A_IRQMASK = 3'd2;
    localparam logic [2:0] A_EDGECAP = 3'd3;
    localparam logic [2:0] A_OUTSET  = 3'd4;
    localparam logic [2:0] A_OUTCLR  = 3'd5;
`ifdef PIO_BLINK_EN
    localparam logic [2:0] A_BLINKEN = 3'd6;
    localparam logic [2:0] A_BLINKPER = 3'd7;
`endif

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap_clr;

    // Upper writedata bits are deliberately ignored.
    logic unused_wd;
    assign unused_wd = ^writedata;

    assign wr = chipselect & ~write_n;
    assign wd = writedata[WIDTH-1:0];

    // Output register: full write, atomic set, atomic clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= RESET_VALUE;
        end else if (wr) begin
            case (address)
                A_DATA:   data <= wd;
                A_OUTSET: data <= data | wd;
                A_OUTCLR: data <= data & ~wd;
                default:  data <= data;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqmask <= '0;
        end else if (wr && address == A_IRQMASK) begin
            irqmask <= wd;
        end
    end

    // Input synchroniser and one-cycle-delayed copy for edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_det = sync_in & ~prev;
            1:       edge_det = ~sync_in & prev;
            default: edge_det = sync_in ^ prev;
        endcase
    end

    assign cap_clr = (wr && address == A_EDGECAP) ? wd : '0;

    // A new edge overrides a simultaneous write-1-clear of that bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edgecap <= '0;
        end else begin
            edgecap <= (edgecap & ~cap_clr) | edge_det;
        end
    end

    assign irq = |(edgecap & irqmask);

`ifdef PIO_BLINK_EN
    logic [WIDTH-1:0]   blinken;
    logic [BLINK_W-1:0] blinkper;
    logic [BLINK_W-1:0] blink_cnt;
    logic [BLINK_W-1:0] wd_per;
    logic               phase;

    assign wd_per = writedata[BLINK_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blinken <= '0;
        end else if (wr && address == A_BLINKEN) begin
            blinken <= wd;
        end
    end

    // Down-counter: each full count of BLINKPER+1 clocks toggles phase.
    // Writing the period restarts the cycle in the "on" phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blinkper  <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (wr && address == A_BLINKPER) begin
            blinkper  <= wd_per;
            blink_cnt <= wd_per;
            phase     <= 1'b0;
        end else if (blinkper == '0) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == '0) begin
            blink_cnt <= blinkper;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt - 1'b1;
        end
    end

    assign out_port = data & ~(blinken & {WIDTH{phase}});
`else
    localparam int unused_blink_w = BLINK_W;

    assign out_port = data;
`endif

    // Reads are side-effect free and purely combinational.
    always_comb begin
        readdata = '0;
        case (address)
            A_DATA:     readdata = 32'(data);
            A_INPUT:    readdata = 32'(sync_in);
            A_IRQMASK:  readdata = 32'(irqmask);
            A_EDGECAP:  readdata = 32'(edgecap);
`ifdef PIO_BLINK_EN
            A_BLINKEN:  readdata = 32'(blinken);
            A_BLINKPER: readdata = 32'(blinkper);
`endif
            default:    readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_avalon_pio_ext.sv
// Bench for avalon_pio_ext: two instances (rising/2-stage and
// any-edge/3-stage) driven from one bus, compared against a model.
module tb_avalon_pio_ext;

    localparam logic [7:0] RV = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [7:0]  in_port = '0;
    logic [31:0] rd0, rd1;
    logic [7:0]  out0, out1;
    logic        irq0, irq1;
    logic        chk_en = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    avalon_pio_ext #(
        .WIDTH(8), .RESET_VALUE(RV), .EDGE_TYPE(0),
        .SYNC_STAGES(2), .BLINK_W(24)
    ) dut0 (
        .clk(clk), .reset(rst), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd0),
        .in_port(in_port), .out_port(out0), .irq(irq0)
    );

    avalon_pio_ext #(
        .WIDTH(8), .RESET_VALUE(RV), .EDGE_TYPE(2),
        .SYNC_STAGES(3), .BLINK_W(24)
    ) dut1 (
        .clk(clk), .reset(rst), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd1),
        .in_port(in_port), .out_port(out1), .irq(irq1)
    );

    // ---------------- reference model ----------------
    // h[i] = in_port as sampled i+1 clock edges ago.
    logic [7:0]  h [4];
    logic [7:0]  mdata, mmask, mben;
    logic [7:0]  mcap [2];
    logic [23:0] mper;
    longint      t;

    function automatic logic [7:0] edges(int et, logic [7:0] s,
                                          logic [7:0] p);
        logic [7:0] e;
        e = '0;
        for (int b = 0; b < 8; b++) begin
            if (et == 0) e[b] = s[b] && !p[b];
            else if (et == 1) e[b] = !s[b] && p[b];
            else e[b] = s[b] != p[b];
        end
        return e;
    endfunction

    function automatic logic wr_to(logic [2:0] a);
        return chipselect && !write_n && address == a;
    endfunction

    function automatic logic [7:0] next_data();
        logic [7:0] w;
        w = writedata[7:0];
        if (wr_to(3'd0)) return w;
        if (wr_to(3'd4)) return mdata | w;
        if (wr_to(3'd5)) return mdata & ~w;
        return mdata;
    endfunction

    function automatic logic [7:0] clr_mask();
        return wr_to(3'd3) ? writedata[7:0] : 8'h00;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) h[i] <= '0;
            mdata  <= RV;
            mmask  <= '0;
            mcap[0] <= '0;
            mcap[1] <= '0;
            mben   <= '0;
            mper   <= '0;
            t      <= 0;
        end else begin
            mcap[0] <= (mcap[0] & ~clr_mask()) | edges(0, h[1], h[2]);
            mcap[1] <= (mcap[1] & ~clr_mask()) | edges(2, h[2], h[3]);
            mdata <= next_data();
            if (wr_to(3'd2)) mmask <= writedata[7:0];
            if (wr_to(3'd6)) mben <= writedata[7:0];
            if (wr_to(3'd7)) begin
                mper <= writedata[23:0];
                t <= 0;
            end else begin
                t <= t + 1;
            end
            h[0] <= in_port;
            h[1] <= h[0];
            h[2] <= h[1];
            h[3] <= h[2];
        end
    end

    function automatic logic [31:0] mread(int k, logic [2:0] a);
        case (a)
            3'd0: return {24'h0, mdata};
            3'd1: return {24'h0, (k == 0) ? h[1] : h[2]};
            3'd2: return {24'h0, mmask};
            3'd3: return {24'h0, mcap[k]};
`ifdef PIO_BLINK_EN
            3'd6: return {24'h0, mben};
            3'd7: return {8'h0, mper};
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [7:0] mout();
`ifdef PIO_BLINK_EN
        logic ph;
        ph = (mper != 0) &&
             (((t / (longint'(mper) + 1)) % 2) == 1);
        return ph ? (mdata & ~mben) : mdata;
`else
        return mdata;
`endif
    endfunction

    // ---------------- checking ----------------
    task automatic chk(string name, logic [31:0] act,
                       logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_rd0", rd0, mread(0, address));
            chk("cmp_rd1", rd1, mread(1, address));
            chk("cmp_out0", {24'h0, out0}, {24'h0, mout()});
            chk("cmp_out1", {24'h0, out1}, {24'h0, mout()});
            chk("cmp_irq0", {31'h0, irq0},
                {31'h0, |(mcap[0] & mmask)});
            chk("cmp_irq1", {31'h0, irq1},
                {31'h0, |(mcap[1] & mmask)});
        end
    end

    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic bus_write(logic [2:0] a, logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rdchk(string name, int k, logic [2:0] a,
                         logic [31:0] exp);
        address = a;
        #1;
        chk(name, (k == 0) ? rd0 : rd1, exp);
    endtask

    initial begin
        step();
        chk_en = 1'b1;
        step();
        // reset state
        chk("rst_out", {24'h0, out0}, 32'hA5);
        chk("rst_irq", {31'h0, irq0}, 32'h0);
        rdchk("rst_in", 0, 3'd1, 32'h0);
        rdchk("rst_mask", 0, 3'd2, 32'h0);
        rdchk("rst_cap", 0, 3'd3, 32'h0);
        rst = 1'b0;
        step();

        bus_write(3'd0, 32'h3C);
        chk("data_out", {24'h0, out0}, 32'h3C);
        rdchk("data_rd", 0, 3'd0, 32'h3C);

        bus_write(3'd0, 32'h0F);
        bus_write(3'd4, 32'h30);
        rdchk("outset", 0, 3'd0, 32'h3F);
        bus_write(3'd5, 32'h05);
        rdchk("outclr", 0, 3'd0, 32'h3A);
        rdchk("rd_set0", 0, 3'd4, 32'h0);
        rdchk("rd_clr0", 0, 3'd5, 32'h0);

        // rising capture, 2-stage sync
        bus_write(3'd2, 32'h01);
        in_port = 8'h01;
        step();
        rdchk("in_n1", 0, 3'd1, 32'h0);
        step();
        rdchk("in_n2", 0, 3'd1, 32'h1);
        rdchk("cap_n2", 0, 3'd3, 32'h0);
        step();
        rdchk("cap_n3", 0, 3'd3, 32'h1);
        chk("irq_n3", {31'h0, irq0}, 32'h1);
        bus_write(3'd3, 32'h01);
        chk("irq_clr", {31'h0, irq0}, 32'h0);

        // clear/set collision on bit0, plain clear on bit1
        in_port = 8'h02;
        step(4);
        rdchk("cap_b1", 0, 3'd3, 32'h2);
        chk("irq_b1", {31'h0, irq0}, 32'h0);
        in_port = 8'h03;
        step(2);
        bus_write(3'd3, 32'h03);
        rdchk("collide", 0, 3'd3, 32'h1);
        chk("collide_irq", {31'h0, irq0}, 32'h1);

        // masking with any-edge instance
        bus_write(3'd2, 32'h00);
        in_port = 8'h00;
        step(6);
        bus_write(3'd3, 32'hFF);
        rdchk("any_clr", 1, 3'd3, 32'h0);
        in_port = 8'h08;
        step();
        in_port = 8'h00;
        step(6);
        rdchk("any_cap", 1, 3'd3, 32'h8);
        chk("any_masked", {31'h0, irq1}, 32'h0);
        bus_write(3'd2, 32'h08);
        chk("any_unmask", {31'h0, irq1}, 32'h1);

        // asynchronous reset mid-cycle
        in_port = 8'h55;
        bus_write(3'd0, 32'h12);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out", {24'h0, out0}, 32'hA5);
        chk("arst_irq", {31'h0, irq0}, 32'h0);
        in_port = 8'h00;
        step(2);
        rst = 1'b0;
        step(5);
        rdchk("arst_cap", 0, 3'd3, 32'h0);

`ifdef PIO_BLINK_EN
        bus_write(3'd0, 32'hFF);
        bus_write(3'd6, 32'h01);
        bus_write(3'd7, 32'h3);
        chk("blink_on", {24'h0, out0}, 32'hFF);
        step(4);
        chk("blink_off", {24'h0, out0}, 32'hFE);
        rdchk("blink_rd", 0, 3'd0, 32'hFF);
        step(4);
        chk("blink_on2", {24'h0, out0}, 32'hFF);
        bus_write(3'd7, 32'h0);
        step(5);
        chk("blink_stop", {24'h0, out0}, 32'hFF);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                #1;
                rst = 1'b1;
                in_port = 8'($urandom);
                step(2);
                rst = 1'b0;
            end
            address = 3'($urandom_range(0, 7));
            writedata = $urandom;
            if (address == 3'd7) writedata = $urandom_range(0, 6);
            chipselect = 1'($urandom_range(0, 1));
            write_n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 3)
                in_port = in_port ^ 8'($urandom);
            step();
        end
        chipselect = 1'b0;
        write_n = 1'b1;
        step(2);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_pio_ext.md
Name: avalon_pio_ext

Overview:
- Parametrised successor to the single-register LED output port.
- Zero-wait-state Avalon-MM slave providing:
  - a WIDTH-bit output register with atomic bit set/clear;
  - a synchronised input port with per-bit edge capture and a maskable level interrupt.
- Sits between the Nios II data master and board-level LEDs, switches and push-buttons.
- Replaces separate output-only and input-only PIO instances.

Parameters:
- WIDTH, 8, number of output bits and input bits (1..32).
- RESET_VALUE, 0, value loaded into the output register at reset (WIDTH bits).
- EDGE_TYPE, 0, edge capture type: 0 rising, 1 falling, 2 any.
- SYNC_STAGES, 2, flip-flop stages on in_port before edge detection (2..4).
- BLINK_W, 24, width of the blink period register (used only with PIO_BLINK_EN).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  register word select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; bits above WIDTH are ignored.
- readdata  out  32  read data, combinational from address; zero-extended.
- in_port  in  WIDTH  asynchronous external inputs.
- out_port  out  WIDTH  output pins.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Register map (word address):
  - 0 DATA: R/W output register.
  - 1 INPUT: RO, synchronised in_port.
  - 2 IRQMASK: R/W.
  - 3 EDGECAP: R; write 1 to clear.
  - 4 OUTSET: WO, reads 0.
  - 5 OUTCLR: WO, reads 0.
  - 6 BLINKEN and 7 BLINKPER: as under Optional Feature, otherwise read 0 and ignore writes.
- Write condition: chipselect & ~write_n. The register updates on that clock edge.
- Read latency 0: readdata is a pure function of address and the current register state. Reads have no side effects.
- OUTSET: data <= data | wd.
- OUTCLR: data <= data & ~wd.
- DATA write: full replace.
- Reset values:
  - data = RESET_VALUE;
  - IRQMASK = 0;
  - EDGECAP = 0;
  - synchroniser chain = 0;
  - prev-sample = 0;
  - irq = 0;
  - out_port = RESET_VALUE.
- Input path: in_port passes through SYNC_STAGES flops to give sync_in. INPUT reads sync_in, so a change on in_port is visible after SYNC_STAGES clocks.
- Edge detect compares sync_in against a one-cycle-delayed copy prev:
  - rising: sync_in & ~prev;
  - falling: ~sync_in & prev;
  - any: sync_in ^ prev.
- EDGECAP bit is set on the clock after the edge is detected, i.e. SYNC_STAGES+1 clocks after the in_port change. It is sticky until cleared.
- Simultaneous EDGECAP write-1-clear and a new edge on the same bit: the set wins and the bit stays 1. Clearing other bits is unaffected.
- irq = |(EDGECAP & IRQMASK), decoded from registers with no extra delay. It deasserts in the cycle after the clearing write or the mask write.
- Asynchronous reset asserted mid-operation: all state returns to reset values immediately. Pending captures are discarded, and an edge present on in_port at release is not captured unless it occurs after release.

Optional Feature:
- Macro: PIO_BLINK_EN.
- Defined:
  - Adds BLINKEN (addr 6, WIDTH bits, R/W, reset 0) and BLINKPER (addr 7, BLINK_W bits, R/W, reset 0).
  - A down-counter reloads from BLINKPER. When it reaches 0 it reloads and toggles the phase bit.
  - out_port = data & ~(BLINKEN & {WIDTH{phase}}), so enabled bits are on for BLINKPER+1 clocks, then off for BLINKPER+1 clocks.
  - BLINKPER = 0: phase is held at 0, so there is no blinking.
  - Writing BLINKPER reloads the counter with the new value and clears phase in the same edge.
  - DATA/INPUT/EDGECAP reads are unaffected; DATA reads return the register, not out_port.
- Undefined: out_port = data. Addresses 6/7 read 0 and writes are ignored. No counter logic is synthesised.

Test Plan:
- Reset: RESET_VALUE=8'hA5 → out_port=A5, irq=0, reads of addr 1..3 return 0. Write DATA=0x3C → out_port=3C next cycle, read addr0=0x0000003C.
- Set/clear: DATA=0x0F, OUTSET 0x30 → 0x3F; OUTCLR 0x05 → 0x3A; reads of addr4/5 return 0.
- Rising capture, SYNC_STAGES=2: IRQMASK=0x01, in_port[0] 0→1 at cycle N → INPUT bit0=1 at N+2, EDGECAP=0x01 and irq=1 at N+3. Write EDGECAP 0x01 → irq=0 the next cycle.
- Clear/set collision: a new rising edge on bit0 detected in the same cycle as a write-1-clear to EDGECAP bit0 → EDGECAP bit0 stays 1, irq stays 1.
- Masking: EDGE_TYPE=2, pulse in_port[3] → EDGECAP=0x08 and irq=0 while IRQMASK=0. Set IRQMASK=0x08 → irq=1 next cycle.
- PIO_BLINK_EN: DATA=0xFF, BLINKEN=0x01, BLINKPER=3 → out_port alternates FF/FE every 4 clocks. BLINKPER=0 → out_port holds FF.
